// File: rtl/nand_pkg.sv
// Shared constants and packed-bus offset helper for the pipelined NAND chain.
package nand_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STAGES = 3;
  localparam int DEF_CNT_W  = 16;

  // Bit offset of tap k or operand i inside a packed bus of WIDTH-bit lanes.
  function automatic int lane_off(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/nand_pipe_stage.sv
// One gate stage of the NAND chain: valid bit, stall-chain advance, and registered
// tap/operand vectors. Stage 0 gates x0 in place of a previous tap.
module nand_pipe_stage
  import nand_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int IDX    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        up_valid,
  input  logic [STAGES*WIDTH-1:0]     up_taps,
  input  logic [(STAGES+1)*WIDTH-1:0] up_ops,
  input  logic                        down_adv,
  output logic                        adv,
  output logic                        valid_q,
  output logic [STAGES*WIDTH-1:0]     taps_q,
  output logic [(STAGES+1)*WIDTH-1:0] ops_q
);

  localparam int TW = STAGES * WIDTH;
  localparam int OW = (STAGES + 1) * WIDTH;
  // Taps below this stage are carried; operands up to x(IDX+1) are consumed and zeroed.
  localparam logic [TW-1:0] KEEP_TAPS = (TW'(1) << lane_off(IDX, WIDTH)) - TW'(1);
  localparam logic [OW-1:0] KEEP_OPS  = ~((OW'(1) << lane_off(IDX + 2, WIDTH)) - OW'(1));

  logic [WIDTH-1:0] prev_s;
  logic [WIDTH-1:0] gate_s;
  logic             valid_d;
  logic [TW-1:0]    taps_d;
  logic [OW-1:0]    ops_d;

  generate
    if (IDX == 0) begin : g_first
      assign prev_s = up_ops[WIDTH-1:0];
    end else begin : g_chain
      assign prev_s = up_taps[lane_off(IDX - 1, WIDTH) +: WIDTH];
    end
  endgenerate

  assign gate_s = ~(prev_s & up_ops[lane_off(IDX + 1, WIDTH) +: WIDTH]);
  assign adv    = ~valid_q | down_adv;

  // Next-state: load from upstream when advancing, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    taps_d  = taps_q;
    ops_d   = ops_q;
    if (adv) begin
      valid_d = up_valid;
      if (up_valid) begin
        taps_d = (up_taps & KEEP_TAPS) | (TW'(gate_s) << lane_off(IDX, WIDTH));
        ops_d  = up_ops & KEEP_OPS;
      end else begin
        taps_d = taps_q;
        ops_d  = ops_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      taps_q  <= '0;
      ops_q   <= '0;
    end else begin
      valid_q <= valid_d;
      taps_q  <= taps_d;
      ops_q   <= ops_d;
    end
  end

endmodule

// File: rtl/nand_chain_pipe.sv
// Pipelined, parametrised NAND chain with valid/ready handshakes, full backpressure
// and a saturating completed-result counter.
module nand_chain_pipe
  import nand_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(STAGES+1)*WIDTH-1:0] in_ops,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [STAGES*WIDTH-1:0]     out_taps,
  output logic [CNT_W-1:0]            done_cnt
);

  localparam int TW = STAGES * WIDTH;
  localparam int OW = (STAGES + 1) * WIDTH;

  logic          adv_s     [STAGES+1];
  logic          v_s       [STAGES];
  logic          up_v_s    [STAGES];
  logic [TW-1:0] taps_s    [STAGES];
  logic [TW-1:0] up_taps_s [STAGES];
  logic [OW-1:0] ops_s     [STAGES];
  logic [OW-1:0] up_ops_s  [STAGES];

  logic             rdy_en_q;
  logic             rdy_en_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             unused_s;

  assign adv_s[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_src
        assign up_v_s[k]    = in_valid & rdy_en_q;
        assign up_taps_s[k] = '0;
        assign up_ops_s[k]  = in_ops;
      end else begin : g_link
        assign up_v_s[k]    = v_s[k-1];
        assign up_taps_s[k] = taps_s[k-1];
        assign up_ops_s[k]  = ops_s[k-1];
      end

      nand_pipe_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .IDX    (k)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (up_v_s[k]),
        .up_taps  (up_taps_s[k]),
        .up_ops   (up_ops_s[k]),
        .down_adv (adv_s[k+1]),
        .adv      (adv_s[k]),
        .valid_q  (v_s[k]),
        .taps_q   (taps_s[k]),
        .ops_q    (ops_s[k])
      );
    end
  endgenerate

  // The last stage has consumed every operand, so its operand register is always zero.
  assign unused_s = ^ops_s[STAGES-1];

  // Input acceptance is enabled from the first clock edge after reset release.
  always_comb begin
    rdy_en_d = 1'b1;
  end

  // Counter next-state: count accepted results, saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (v_s[STAGES-1] && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Ready-enable and result counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = adv_s[0] & rdy_en_q;
  assign out_valid = v_s[STAGES-1];
  assign out_taps  = taps_s[STAGES-1];
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_nand_chain_pipe.sv
// Directed self-checking bench for nand_chain_pipe: a 4-lane instance (a_*) and a
// 1-lane instance with a 4-bit counter (b_*) for the saturation case.
module tb_nand_chain_pipe;

  logic clk;
  logic rst_n;

  logic        a_valid, a_ready, a_ovalid, a_oready;
  logic [15:0] a_ops;
  logic [11:0] a_taps;
  logic [15:0] a_cnt;

  logic        b_valid, b_ready, b_ovalid, b_oready;
  logic [3:0]  b_ops;
  logic [2:0]  b_taps;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_err    = 0;

  nand_chain_pipe #(.WIDTH(4), .STAGES(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_ops(a_ops),
    .out_valid(a_ovalid), .out_ready(a_oready), .out_taps(a_taps), .done_cnt(a_cnt)
  );

  nand_chain_pipe #(.WIDTH(1), .STAGES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_ops(b_ops),
    .out_valid(b_ovalid), .out_ready(b_oready), .out_taps(b_taps), .done_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference chain for 4 lanes, 3 gates.
  function automatic logic [11:0] model(input logic [15:0] ops);
    logic [3:0]  t;
    logic [11:0] r;
    t = ~(ops[3:0] & ops[7:4]);   r[3:0]  = t;
    t = ~(t & ops[11:8]);         r[7:4]  = t;
    t = ~(t & ops[15:12]);        r[11:8] = t;
    return r;
  endfunction

  logic [15:0] vec [16];
  logic [15:0] pv  [4];
  logic [11:0] sbq [$];
  int pops;
  int pushes;

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_ops = 16'h0000; a_oready = 1'b0;
    b_valid = 1'b0; b_ops = 4'h0;     b_oready = 1'b0;
    for (int i = 0; i < 16; i++) vec[i] = 16'(i * 40503 + 23130);
    vec[0] = 16'hFFFF;
    pv[0] = 16'h1234; pv[1] = 16'hABCD; pv[2] = 16'hF0F0; pv[3] = 16'h0F0F;

    // Reset state
    #2;
    chk("rst_out_valid", a_ovalid, 1'b0);
    chk("rst_out_taps", a_taps, 12'h000);
    chk("rst_done_cnt", a_cnt, 16'h0000);
    chk("rst_in_ready_low", a_ready, 1'b0);
    #10 rst_n = 1'b1;
    tick;
    chk("post_rst_in_ready", a_ready, 1'b1);

    // Test 1: WIDTH=1 single vector, x0=1 x1=1 x2=0 x3=1
    b_valid = 1'b1; b_ops = 4'b1011; b_oready = 1'b1;
    tick;
    b_valid = 1'b0;
    chk("t1_lat_c1", b_ovalid, 1'b0);
    tick;
    chk("t1_lat_c2", b_ovalid, 1'b0);
    tick;
    chk("t1_lat_c3", b_ovalid, 1'b1);
    chk("t1_taps", b_taps, 3'b010);
    tick;
    chk("t1_drained", b_ovalid, 1'b0);
    chk("t1_cnt", b_cnt, 4'd1);

    // Test 2: 16-vector stream with out_ready high
    a_oready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("t2_out_valid", a_ovalid, (i >= 3 && i <= 18) ? 1'b1 : 1'b0);
      if (i >= 3 && i <= 18) chk("t2_taps", a_taps, model(vec[i-3]));
      if (i == 3) chk("t2_hand_ffff", a_taps, 12'h0F0);
      if (i < 16) begin
        a_valid = 1'b1; a_ops = vec[i];
        chk("t2_in_ready", a_ready, 1'b1);
      end else begin
        a_valid = 1'b0;
      end
      tick;
    end
    chk("t2_done_cnt", a_cnt, 16'd16);

    // Test 3: fill, stall for 5 cycles, then drain
    a_oready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      a_valid = 1'b1; a_ops = pv[p];
      tick;
    end
    a_ops = pv[3];
    #1;
    chk("t3_full_in_ready", a_ready, 1'b0);
    chk("t3_full_out_valid", a_ovalid, 1'b1);
    chk("t3_full_taps", a_taps, model(pv[0]));
    for (int s = 0; s < 5; s++) begin
      tick;
      chk("t3_stall_in_ready", a_ready, 1'b0);
      chk("t3_stall_out_valid", a_ovalid, 1'b1);
      chk("t3_stall_taps", a_taps, model(pv[0]));
    end
    a_oready = 1'b1;
    #1;
    chk("t3_release_in_ready", a_ready, 1'b1);
    tick;
    a_valid = 1'b0;
    chk("t3_drain1", a_taps, model(pv[1]));
    tick;
    chk("t3_drain2", a_taps, model(pv[2]));
    tick;
    chk("t3_drain3", a_taps, model(pv[3]));
    chk("t3_drain3_valid", a_ovalid, 1'b1);
    tick;
    chk("t3_empty", a_ovalid, 1'b0);
    chk("t3_done_cnt", a_cnt, 16'd20);

    // Test 4: out_ready toggling, in_valid held; capacity-3 scoreboard
    pops = 0; pushes = 0;
    for (int i = 0; i < 28; i++) begin
      a_valid  = (i < 20) ? 1'b1 : 1'b0;
      a_ops    = 16'(i * 4951 + 2766);
      a_oready = (i < 20) ? ((i % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
      #1;
      chk("t4_in_ready", a_ready, ((sbq.size() < 3) || a_oready) ? 1'b1 : 1'b0);
      if (a_ovalid) begin
        if (sbq.size() == 0) chk("t4_spurious", a_ovalid, 1'b0);
        else chk("t4_order", a_taps, sbq[0]);
      end
      if (a_ovalid && a_oready && sbq.size() > 0) begin
        void'(sbq.pop_front());
        pops++;
      end
      if (a_valid && a_ready) begin
        sbq.push_back(model(a_ops));
        pushes++;
      end
      tick;
    end
    a_valid = 1'b0;
    chk("t4_queue_empty", sbq.size(), 0);
    chk("t4_no_loss", pops, pushes);
    chk("t4_done_cnt", a_cnt, 16'(20 + pops));

    // Test 5: async reset mid-stream with 2 results in flight
    a_valid = 1'b1; a_ops = 16'h1111; a_oready = 1'b1;
    tick;
    a_ops = 16'h2222;
    tick;
    a_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", a_ovalid, 1'b0);
    chk("t5_rst_done_cnt", a_cnt, 16'h0000);
    chk("t5_rst_in_ready", a_ready, 1'b0);
    chk("t5_rst_b_cnt", b_cnt, 4'd0);
    #2 rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick;
      chk("t5_no_stale", a_ovalid, 1'b0);
    end
    chk("t5_cnt_after", a_cnt, 16'h0000);

    // Test 6: 4-bit counter saturates after 20 accepted results
    b_oready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      b_valid = (i < 20) ? 1'b1 : 1'b0;
      b_ops   = 4'(i);
      tick;
    end
    chk("t6_sat_cnt", b_cnt, 4'd15);
    chk("t6_idle", b_ovalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
